// File: rtl/des_sbox_engine.sv
// des_sbox_engine
//   DES substitution stage: runs the 48-bit expanded/key-mixed word through
//   S1..S8 and returns the 32-bit concatenation, BOXES_PER_CYCLE boxes per
//   clock (legal values 1, 2, 4, 8).
//   Optional build macro: DES_SBOX_PERM_EN -- when defined, the result is
//   passed through the DES P permutation in a register loaded on the
//   RUN->DONE transfer; latency is unchanged. When undefined, out_bits is the
//   raw S-box concatenation and no P logic exists.
//
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both high. out_valid, once high, holds with stable out_bits until the
//   edge where out_ready is sampled high. in_ready is combinational: high in
//   IDLE, and high in DONE exactly when out_ready is high, so a result can be
//   taken and a new word accepted on the same edge.
//
//   FSM state is held in state_q (fsm_state_t) for probing and binding.
module des_sbox_engine #(
   parameter int BOXES_PER_CYCLE = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [47:0] in_bits,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_bits,
   output logic        busy
);

   // Reject unsupported box counts when the design is elaborated.
   if (!(BOXES_PER_CYCLE == 1 || BOXES_PER_CYCLE == 2 ||
         BOXES_PER_CYCLE == 4 || BOXES_PER_CYCLE == 8)) begin : g_bad_bpc
      $error("des_sbox_engine: BOXES_PER_CYCLE must be 1, 2, 4 or 8");
   end

   localparam int NUM_GROUPS = 8 / BOXES_PER_CYCLE;
   localparam int CNT_W      = $clog2(NUM_GROUPS) + 1;
   localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NUM_GROUPS - 1);

   // S-box tables, row-major (row 0 col 0 in the top nibble), 64 nibbles each.
   localparam logic [255:0] S1_TBL =
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
   localparam logic [255:0] S2_TBL =
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
   localparam logic [255:0] S3_TBL =
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
   localparam logic [255:0] S4_TBL =
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
   localparam logic [255:0] S5_TBL =
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
   localparam logic [255:0] S6_TBL =
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
   localparam logic [255:0] S7_TBL =
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
   localparam logic [255:0] S8_TBL =
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_state_t;

   fsm_state_t       state_q, state_d;
   logic [47:0]      in_q, in_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      result_q, result_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             accept;

   // One S-box lookup: row = {b5,b0}, col = b4..b1, i.e. table index {b5,b0,b4..b1}.
   function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] b);
      logic [255:0] tbl;
      logic [5:0]   idx;
      case (box)
         0:       tbl = S1_TBL;
         1:       tbl = S2_TBL;
         2:       tbl = S3_TBL;
         3:       tbl = S4_TBL;
         4:       tbl = S5_TBL;
         5:       tbl = S6_TBL;
         6:       tbl = S7_TBL;
         default: tbl = S8_TBL;
      endcase
      idx = {b[5], b[0], b[4:1]};
      tbl = tbl << {idx, 2'b00};
      return tbl[255:252];
   endfunction

`ifdef DES_SBOX_PERM_EN
   // P table: output bit i (1 = MSB) takes input bit P_TBL[i-1].
   localparam int P_TBL [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                                  1, 15, 23, 26,  5, 18, 31, 10,
                                  2,  8, 24, 14, 32, 27,  3,  9,
                                 19, 13, 30,  6, 22, 11,  4, 25};

   function automatic logic [31:0] p_perm(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) begin
         y[31-i] = x[32-P_TBL[i]];
      end
      return y;
   endfunction

   logic [31:0] perm_q, perm_d;
`endif

   // Input side ready: free in IDLE, or in DONE when the result is leaving this edge.
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         ST_IDLE: in_ready = 1'b1;
         ST_DONE: in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
      accept = in_valid && in_ready;
   end

   // Next-state, capture, per-group S-box evaluation and output flags.
   always_comb begin
      state_d     = state_q;
      in_d        = in_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
`ifdef DES_SBOX_PERM_EN
      perm_d      = perm_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               in_d     = in_bits;
               cnt_d    = '0;
               result_d = '0;
               busy_d   = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            // Boxes k with k/BPC == cnt form the current group.
            for (int k = 0; k < 8; k++) begin
               if (CNT_W'(k / BOXES_PER_CYCLE) == cnt_q) begin
                  result_d[31-4*k -: 4] = sbox_lookup(k, in_q[47-6*k -: 6]);
               end
            end
            if (cnt_q == LAST_GROUP) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               busy_d      = 1'b0;
`ifdef DES_SBOX_PERM_EN
               perm_d      = p_perm(result_d);
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (accept) begin
                  // Result leaves and a new word enters on the same edge.
                  in_d     = in_bits;
                  cnt_d    = '0;
                  result_d = '0;
                  busy_d   = 1'b1;
                  state_d  = ST_RUN;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         in_q        <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef DES_SBOX_PERM_EN
         perm_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         in_q        <= in_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
`ifdef DES_SBOX_PERM_EN
         perm_q      <= perm_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign busy      = busy_q;
`ifdef DES_SBOX_PERM_EN
   assign out_bits  = perm_q;
`else
   assign out_bits  = result_q;
`endif

endmodule
